// File: rtl/piezo_sound_engine.sv
// -----------------------------------------------------------------------------
// piezo_sound_engine
//
// Drives a piezo pin with an engine tone that follows rpm through a rate-limited
// glide. Event beep patterns requested over a req/ack handshake pre-empt that
// tone. Each square wave comes from an exact fractional toggle accumulator, so
// the average output frequency equals the requested frequency in Hz.
//
// Ports:
//   clk        in   1       system clock
//   rst        in   1       asynchronous, active-high reset
//   en         in   1       0 mutes the output (timing and glide keep running)
//   rpm        in   RPM_W   engine rpm, unsigned
//   evt_req    in   1       event request, held high until evt_ack
//   evt_hi     in   1       event tone select (0 = EVT_FREQ_LO, 1 = EVT_FREQ_HI)
//   evt_count  in   3       number of beeps, 0 treated as 1
//   evt_ack    out  1       one-cycle pulse when a request is accepted
//   evt_busy   out  1       high while an event pattern runs
//   cur_freq   out  FREQ_W  engine glide frequency in Hz
//   piezo_out  out  1       square-wave drive
// -----------------------------------------------------------------------------
module piezo_sound_engine #(
   parameter int INPUT_FREQ     = 50_000_000,
   parameter int FREQ_MIN       = 200,
   parameter int FREQ_MAX       = 2000,
   parameter int RPM_MAX        = 8000,
   parameter int RPM_W          = 14,
   parameter int FREQ_W         = 13,
   parameter int TICK_CLKS      = 50_000,
   parameter int SLEW_STEP      = 20,
   parameter int EVT_FREQ_LO    = 1000,
   parameter int EVT_FREQ_HI    = 4000,
   parameter int BEEP_ON_TICKS  = 100,
   parameter int BEEP_OFF_TICKS = 50
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [RPM_W-1:0]  rpm,
   input  logic              evt_req,
   input  logic              evt_hi,
   input  logic [2:0]        evt_count,
   output logic              evt_ack,
   output logic              evt_busy,
   output logic [FREQ_W-1:0] cur_freq,
   output logic              piezo_out
);

   // ---------------------------------------------------------------------------
   // Derived constants
   // ---------------------------------------------------------------------------
   localparam int ON_CLKS  = BEEP_ON_TICKS * TICK_CLKS;
   localparam int OFF_CLKS = BEEP_OFF_TICKS * TICK_CLKS;
   localparam int PH_MAX   = (ON_CLKS > OFF_CLKS) ? ON_CLKS : OFF_CLKS;
   localparam int PH_W     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
   localparam int TICK_W   = (TICK_CLKS > 1) ? $clog2(TICK_CLKS) : 1;
   // Accumulator stays below INPUT_FREQ; one step adds at most 2*(2^FREQ_W - 1).
   localparam int ACC_W    = $clog2(INPUT_FREQ + 2 * (2 ** FREQ_W));
   localparam int PROD_W   = RPM_W + FREQ_W;

   localparam logic [RPM_W-1:0]  RPM_MAX_V = RPM_W'(RPM_MAX);
   localparam logic [FREQ_W-1:0] FMIN_V    = FREQ_W'(FREQ_MIN);
   localparam logic [FREQ_W-1:0] STEP_V    = FREQ_W'(SLEW_STEP);
   localparam logic [FREQ_W-1:0] EVT_LO_V  = FREQ_W'(EVT_FREQ_LO);
   localparam logic [FREQ_W-1:0] EVT_HI_V  = FREQ_W'(EVT_FREQ_HI);
   localparam logic [ACC_W-1:0]  IN_F_V    = ACC_W'(INPUT_FREQ);
   localparam logic [PH_W-1:0]   ON_LAST   = PH_W'(ON_CLKS - 1);
   localparam logic [PH_W-1:0]   OFF_LAST  = PH_W'(OFF_CLKS - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CLKS - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ON   = 2'd1;
   localparam logic [1:0] S_OFF  = 2'd2;

   // ---------------------------------------------------------------------------
   // Target frequency: linear map of the clamped rpm, registered
   // ---------------------------------------------------------------------------
   logic [RPM_W-1:0]  rpm_c;
   logic [PROD_W-1:0] scaled;
   logic [FREQ_W-1:0] target_nxt;
   logic [FREQ_W-1:0] target;

   // NOTE: every signal assigned in always_comb gets a value on every path, so
   // no latch can be inferred.
   always_comb begin
      rpm_c      = (rpm > RPM_MAX_V) ? RPM_MAX_V : rpm;
      scaled     = (PROD_W'(rpm_c) * PROD_W'(FREQ_MAX - FREQ_MIN)) / PROD_W'(RPM_MAX);
      target_nxt = FMIN_V + FREQ_W'(scaled);
   end

   // NOTE: sequential state uses non-blocking assignments, so every register
   // samples the values from before the clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) target <= FMIN_V;
      else     target <= target_nxt;
   end

   // ---------------------------------------------------------------------------
   // Glide: free-running tick counter. The tone moves one step toward the
   // target on each wrap. The differences are formed in the safe direction, so
   // the step never overshoots and never overflows.
   // ---------------------------------------------------------------------------
   logic [TICK_W-1:0] tick_cnt;
   logic              tick;
   logic [FREQ_W-1:0] glide_nxt;

   assign tick = (tick_cnt == TICK_LAST);

   always_comb begin
      glide_nxt = cur_freq;
      if (cur_freq < target)
         glide_nxt = ((target - cur_freq) > STEP_V) ? cur_freq + STEP_V : target;
      else if (cur_freq > target)
         glide_nxt = ((cur_freq - target) > STEP_V) ? cur_freq - STEP_V : target;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt <= '0;
         cur_freq <= FMIN_V;
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
         if (tick) cur_freq <= glide_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Event FSM: IDLE -> ON -> (OFF -> ON)* -> IDLE.
   // The phase timer restarts on every state entry.
   // ---------------------------------------------------------------------------
   logic [1:0]      state;
   logic [1:0]      state_nxt;
   logic [PH_W-1:0] ph_cnt;
   logic [2:0]      rem;
   logic            evt_hi_q;
   logic            state_chg;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (evt_req) state_nxt = S_ON;
         S_ON:    if (ph_cnt == ON_LAST) state_nxt = (rem == 3'd1) ? S_IDLE : S_OFF;
         S_OFF:   if (ph_cnt == OFF_LAST) state_nxt = S_ON;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign state_chg = (state_nxt != state);
   assign evt_busy  = (state != S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         ph_cnt   <= '0;
         rem      <= 3'd0;
         evt_hi_q <= 1'b0;
         evt_ack  <= 1'b0;
      end else begin
         state   <= state_nxt;
         ph_cnt  <= state_chg ? '0 : ph_cnt + PH_W'(1);
         evt_ack <= (state == S_IDLE) && evt_req;
         if (state == S_IDLE && evt_req) begin
            rem      <= (evt_count == 3'd0) ? 3'd1 : evt_count;
            evt_hi_q <= evt_hi;
         end else if (state == S_ON && state_chg) begin
            rem <= rem - 3'd1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Tone generator: Bresenham-style accumulator. Adding 2f each clock and
   // wrapping at INPUT_FREQ gives 2f toggles per second, so the average output
   // frequency is exactly f. A state change restarts the phase from zero so
   // the source switch is glitch-free. OFF and mute hold the pin low and
   // freeze the phase.
   // ---------------------------------------------------------------------------
   logic [FREQ_W-1:0] f_act;
   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  acc_sum;

   always_comb begin
      f_act   = (state == S_ON) ? (evt_hi_q ? EVT_HI_V : EVT_LO_V) : cur_freq;
      acc_sum = acc + ACC_W'({f_act, 1'b0});
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc       <= '0;
         piezo_out <= 1'b0;
      end else if (state_chg) begin
         acc       <= '0;
         piezo_out <= 1'b0;
      end else if (state == S_OFF || !en) begin
         piezo_out <= 1'b0;
      end else if (acc_sum >= IN_F_V) begin
         acc       <= acc_sum - IN_F_V;
         piezo_out <= ~piezo_out;
      end else begin
         acc <= acc_sum;
      end
   end

endmodule

// File: doc/piezo_sound_engine.md
Name: piezo_sound_engine

Overview:
- Next-generation piezo driver. Produces an engine tone that tracks rpm with a rate-limited glide, plus pre-emptive event beep patterns (shift warning, alerts) requested over a req/ack handshake.
- Replaces the per-cycle integer divider with an exact fractional (Bresenham) toggle accumulator.
- Sits between the engine model (rpm source), the event/alert logic and the piezo pin.

Parameters:
- INPUT_FREQ, 50_000_000, clk frequency in Hz.
- FREQ_MIN, 200, engine tone at rpm 0, in Hz.
- FREQ_MAX, 2000, engine tone at rpm >= RPM_MAX, in Hz.
- RPM_MAX, 8000, rpm mapped to FREQ_MAX.
- RPM_W, 14, width of the rpm input.
- FREQ_W, 13, width of frequency registers; must hold max(FREQ_MAX, EVT_FREQ_HI).
- TICK_CLKS, 50_000, clocks per glide tick (1 ms at default).
- SLEW_STEP, 20, maximum change of the engine tone per tick, in Hz.
- EVT_FREQ_LO, 1000, event tone when evt_hi = 0, in Hz.
- EVT_FREQ_HI, 4000, event tone when evt_hi = 1, in Hz.
- BEEP_ON_TICKS, 100, beep on-time, in ticks.
- BEEP_OFF_TICKS, 50, gap between beeps, in ticks.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  0 mutes the output
- rpm  in  RPM_W  engine rpm, unsigned
- evt_req  in  1  event request, level-held until ack
- evt_hi  in  1  selects event tone (0 = LO, 1 = HI)
- evt_count  in  3  number of beeps; 0 treated as 1
- evt_ack  out  1  one-cycle pulse on acceptance
- evt_busy  out  1  high while an event pattern runs
- cur_freq  out  FREQ_W  engine glide frequency in Hz, after slew
- piezo_out  out  1  square-wave drive

Behaviour:
- Reset values: piezo_out = 0, evt_ack = 0, evt_busy = 0, cur_freq = FREQ_MIN. Also cleared on reset: target register (= FREQ_MIN), accumulator, tick counter, FSM = IDLE.
- Target frequency:
  - rpm_c = min(rpm, RPM_MAX).
  - target = FREQ_MIN + rpm_c*(FREQ_MAX-FREQ_MIN)/RPM_MAX, truncating, with intermediates wide enough not to overflow.
  - Registered, so there is 1 cycle of latency from rpm to target.
- Glide:
  - The tick counter is free-running, 0..TICK_CLKS-1. A tick occurs on wrap.
  - On a tick: if cur_freq < target, cur_freq = min(cur_freq+SLEW_STEP, target); if cur_freq > target, cur_freq = max(cur_freq-SLEW_STEP, target).
  - Glide continues during events and while muted.
- Tone generator:
  - Active frequency f is the event tone when the FSM is in ON, otherwise cur_freq.
  - Every clock: acc += 2*f. If the sum >= INPUT_FREQ, subtract INPUT_FREQ and toggle piezo_out.
  - Average output frequency is exactly f; half-period is INPUT_FREQ/(2f) clocks when that is an integer.
  - acc is cleared and piezo_out forced 0 on every FSM state change (glitch-free source switch).
- Event FSM, states IDLE / ON / OFF:
  - IDLE: evt_busy = 0. If evt_req = 1: latch rem = max(evt_count,1) and evt_hi, pulse evt_ack next cycle, go to ON. evt_busy goes to 1 in the same cycle as the ack.
  - ON: lasts exactly BEEP_ON_TICKS*TICK_CLKS clocks, timed by a dedicated phase timer cleared on every state entry (independent of glide ticks). At end: rem -= 1; if rem = 0 go to IDLE, else go to OFF.
  - OFF: piezo_out held 0 for exactly BEEP_OFF_TICKS*TICK_CLKS clocks, then ON.
  - No trailing gap after the last beep; engine tone resumes in IDLE from acc = 0.
  - evt_req while busy is ignored (no ack, not queued). If req is still high on return to IDLE, it is accepted then.
- Mute: en = 0 forces piezo_out = 0 and holds acc. FSM timing and glide keep running. en rising resumes toggling from the held acc.
- Reset mid-event: immediate abort, all reset values. No ack or busy afterwards.

Test Plan (INPUT_FREQ=1_000_000, TICK_CLKS=1000, SLEW_STEP=100, BEEP_ON_TICKS=2, BEEP_OFF_TICKS=1, other parameters default, en=1):
- Reset release, rpm=0 -> cur_freq=200; piezo_out toggles every 2500 clocks; evt_busy=0.
- rpm steps 0->8000 -> cur_freq rises 100 per tick, reaches 2000 after 18 ticks, then stays; half-period 250 clocks; rpm=16383 gives identical behaviour (clamp).
- evt_req=1, evt_hi=1, evt_count=3 in IDLE -> evt_ack single pulse; evt_busy high for exactly 8000 clocks. Pattern: three ON windows of 2000 clocks with toggles every 125 clocks, two OFF windows of 1000 clocks held low. Engine tone then restarts with piezo_out=0.
- evt_req with evt_count=0 -> exactly one 2000-clock beep; second evt_req pulse while busy -> no ack, pattern length unchanged.
- en=0 during engine tone -> piezo_out stays 0, cur_freq still glides; en=1 -> toggling resumes within one half-period.
- rst asserted mid-ON -> piezo_out, evt_busy, evt_ack go 0 asynchronously; cur_freq=200 after release.
